// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and default constants
//
// Purpose: state encoding for the SPI responder and the default frame
// width / idle fill word, shared with the SPI controller side.
// Ports: none (package).

package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int              SPI_DATA_WIDTH = 8;
  localparam logic [7:0]      SPI_FILL_WORD  = 8'hFF;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detection
//
// Purpose: brings one asynchronous pin into the clk_i domain and flags
// its edges by comparing the last synchroniser flop with a history flop.
// Ports:
//   clk_i      in  1  sampling clock
//   reset_n_i  in  1  synchronous active-low reset
//   d_i        in  1  asynchronous input
//   level_o    out 1  synchronised level
//   rise_o     out 1  one-cycle pulse on a 0->1 transition of level_o
//   fall_o     out 1  one-cycle pulse on a 1->0 transition of level_o

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Reset to the pin's idle level so no false edge appears after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level_o = r_sync[SYNC_STAGES-1];
  assign rise_o  =  r_sync[SYNC_STAGES-1] & ~r_hist;
  assign fall_o  = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule : spi_sync_edge

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI mode-0 responder with RX/TX byte streams
//
// Purpose: deserialises PICO frames onto a valid/ready RX stream and
// serialises a held TX word (or the fill word) onto POCI, MSB first.
// Ports:
//   clk_system_i  in  1   system clock
//   reset_n_i     in  1   synchronous active-low reset
//   sck_i         in  1   SPI clock (async)
//   cs_i          in  1   chip select, active-low (async)
//   pico_i        in  1   controller-out data (async)
//   poci_o        out 1   peripheral-out data
//   poci_oe_o     out 1   POCI output enable
//   rx_data_o     out DW  received word
//   rx_valid_o    out 1   rx_data_o valid
//   rx_ready_i    in  1   consumer accepts rx_data_o
//   tx_data_i     in  DW  word to transmit
//   tx_valid_i    in  1   tx_data_i valid
//   tx_ready_o    out 1   holding register empty
//   overrun_o     out 1   sticky: a received word was dropped
//   busy_o        out 1   selected (synchronised chip select)

module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk_system_i,
  input  logic                  reset_n_i,
  input  logic                  sck_i,
  input  logic                  cs_i,
  input  logic                  pico_i,
  output logic                  poci_o,
  output logic                  poci_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_pico;
  logic w_sck_level_unused, w_cs_level_unused;
  logic w_pico_rise_unused, w_pico_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk_i(clk_system_i), .reset_n_i(reset_n_i), .d_i(sck_i),
    .level_o(w_sck_level_unused), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_system_i), .reset_n_i(reset_n_i), .d_i(cs_i),
    .level_o(w_cs_level_unused), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  // Same depth as SCK so PICO is aligned with the detected SCK edge.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_pico_sync (
    .clk_i(clk_system_i), .reset_n_i(reset_n_i), .d_i(pico_i),
    .level_o(w_pico), .rise_o(w_pico_rise_unused), .fall_o(w_pico_fall_unused)
  );

  spi_state_t              r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_full;
  logic                    r_poci, r_poci_oe;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    r_overrun;

  logic                    w_active, w_frame_load, w_word_done, w_tx_fire;
  logic [DATA_WIDTH-1:0]   w_load_word;
  logic [DATA_WIDTH-1:0]   w_rx_word;

  always_ff @(posedge clk_system_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // CS deassertion wins over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_active    = (r_state == ACTIVE) && !w_cs_rise;
  // A frame load happens at selection and on the SCK fall after a full word,
  // which is what allows back-to-back frames under one CS.
  assign w_frame_load = ((r_state == IDLE) && w_cs_fall) ||
                        (w_active && w_sck_fall && (r_bit_cnt == CNT_FULL));
  assign w_word_done = w_active && w_sck_rise && (r_bit_cnt == CNT_LAST);
  assign w_load_word = r_hold_full ? r_hold : FILL_WORD;
  assign w_rx_word   = {r_rx_shift, w_pico};
  assign w_tx_fire   = tx_valid_i && !r_hold_full;

  always_ff @(posedge clk_system_i) begin
    if (!reset_n_i) begin
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_poci      <= 1'b0;
      r_poci_oe   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // A write can only land while empty, so a simultaneous frame load
      // has already taken FILL_WORD and the new word stays held.
      if (w_tx_fire) begin
        r_hold      <= tx_data_i;
        r_hold_full <= 1'b1;
      end else if (w_frame_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_word_done) begin
        if (!r_rx_valid || rx_ready_i) begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end

      if (w_frame_load) begin
        r_tx_shift <= w_load_word;
        r_poci     <= w_load_word[DATA_WIDTH-1];
        r_poci_oe  <= 1'b1;
        r_bit_cnt  <= '0;
      end else if (r_state == ACTIVE) begin
        if (w_cs_rise) begin
          r_poci     <= 1'b0;
          r_poci_oe  <= 1'b0;
          r_bit_cnt  <= '0;
          r_rx_shift <= '0;
        end else begin
          if (w_sck_rise) begin
            r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          end
          if (w_sck_fall) begin
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            r_poci     <= r_tx_shift[DATA_WIDTH-2];
          end
        end
      end
    end
  end

  assign poci_o     = r_poci;
  assign poci_oe_o  = r_poci_oe;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign tx_ready_o = !r_hold_full;
  assign overrun_o  = r_overrun;
  assign busy_o     = (r_state == ACTIVE);

endmodule : spi_peripheral

// File: doc/spi_peripheral.md
# spi_peripheral

SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) that is the target end of the fabric's SPI controller interface (`sck_o`/`cs_o`/`pico_o`/`poci_i`). It oversamples the SPI pins in the `clk_system_i` domain and deserialises received frames onto a valid/ready byte stream. In parallel it serialises bytes supplied on a second valid/ready stream back on POCI. It serves both as a board-level loopback target for bring-up and as the bench responder for controller verification.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per frame.
- `SYNC_STAGES`, 2, synchroniser flops on `sck_i`, `cs_i` and `pico_i` (minimum 2).
- `FILL_WORD`, `{DATA_WIDTH{1'b1}}`, word transmitted when no TX data is held at frame load.

Ports:
- `clk_system_i` in 1: system clock; the only clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `sck_i` in 1: SPI clock, asynchronous.
- `cs_i` in 1: chip select, active-low, asynchronous.
- `pico_i` in 1: controller-out data.
- `poci_o` out 1: peripheral-out data.
- `poci_oe_o` out 1: POCI output enable; high only while selected.
- `rx_data_o` out DATA_WIDTH: received word.
- `rx_valid_o` out 1: `rx_data_o` is valid.
- `rx_ready_i` in 1: consumer accepts the word.
- `tx_data_i` in DATA_WIDTH: word to transmit.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ready_o` out 1: the holding register is empty.
- `overrun_o` out 1: sticky; a received word was dropped.
- `busy_o` out 1: chip select is asserted (synchronised).

## Operation
- Synchronisation and edges:
  - All three inputs pass through `SYNC_STAGES` flops.
  - `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise` come from comparing the last synchroniser flop with one extra history flop.
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on `cs_fall`:
  - Load the TX shift register from the holding register if it is full, otherwise load `FILL_WORD`.
  - The holding register is consumed by that load.
  - Bit counter ← 0.
  - `poci_oe_o` ← 1.
  - `poci_o` ← MSB of the loaded word.
- In ACTIVE:
  - On `sck_rise`: shift the synchronised `pico_i` into the RX shift register (LSB in) and increment the bit counter.
  - On `sck_fall`: shift the TX register left and drive the new MSB.
  - Exception: if the bit counter equals `DATA_WIDTH`, do not shift. Instead reload from the holding register or `FILL_WORD`, set the counter to 0, and drive the reloaded MSB. This gives back-to-back frames within one CS.
- Word completion: the `sck_rise` that makes the counter equal `DATA_WIDTH` completes a word.
  - If `rx_valid_o` is 0: `rx_data_o` ← the assembled word, `rx_valid_o` ← 1.
  - If `rx_valid_o` is 1 and `rx_ready_i` is 0 on that cycle: drop the new word and set `overrun_o`.
  - If `rx_valid_o` is 1 and `rx_ready_i` is 1 on that same cycle: capture the new word and do not flag overrun.
- RX handshake: `rx_valid_o` clears on the cycle after `rx_valid_o && rx_ready_i`, unless a new word is captured that cycle.
- TX handshake:
  - `tx_ready_o = !hold_full`.
  - A transfer happens when `tx_valid_i && tx_ready_o`; the holding register fills on the next edge.
  - If a frame load and `tx_valid_i` occur together while empty, the load uses `FILL_WORD` and the new data fills the holding register.
- ACTIVE → IDLE on `cs_rise`, which takes priority over any same-cycle SCK edge:
  - Discard any partial RX word; no `rx_valid_o` is raised.
  - `poci_oe_o` ← 0, `poci_o` ← 0, counter ← 0.
  - The holding register is kept.
- Reset (`reset_n_i` low at a clock edge, also mid-frame):
  - State IDLE; all shift registers, the counter and the holding register are cleared.
  - Output values: `poci_o`=0, `poci_oe_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `tx_ready_o`=1, `overrun_o`=0, `busy_o`=0.
  - `overrun_o` clears only on reset.

## Timing
- Pin-to-edge latency: `SYNC_STAGES`+1 `clk_system_i` cycles.
- `busy_o` follows `cs_i` with `SYNC_STAGES`+1 cycles of latency.
- POCI:
  - Updates one cycle after the detected `sck_fall`/`cs_fall`.
  - Worst case from SCK pin falling to POCI valid: `SYNC_STAGES`+2 cycles.
- Supported rate: f_sck ≤ f_clk/8. At 12 MHz `clk_system_i` with `SYNC_STAGES`=2 that is 1.5 MHz; this guarantees POCI is settled before the controller's sampling edge.
- Controller CS setup: at least 4 `clk_system_i` cycles from `cs_i` falling to the first SCK rise.
- `rx_valid_o` rises one cycle after the completing `sck_rise` is detected.

## Structure
- Package `spi_pkg`:
  - State enum `spi_state_t` {IDLE, ACTIVE}.
  - Default `DATA_WIDTH` and `FILL_WORD` constants, shared with the controller.
- Sub-module `spi_sync_edge` (parameter `SYNC_STAGES`):
  - One synchroniser plus rise/fall detector.
  - Instanced for `sck_i` and `cs_i`.
  - `pico_i` uses only its synchronised level output.

## Test plan
- Reset, then CS low and 8 SCK clocks of 0xA5 on PICO, then CS high, with the holding register empty → `rx_data_o`=0xA5 with one `rx_valid_o` pulse held until ready; POCI shifts 0xFF.
- Load `tx_data_i`=0x3C, then one frame → POCI bits 0,0,1,1,1,1,0,0 sampled on SCK rises; `tx_ready_o` returns to 1 at `cs_fall`.
- Two frames in one CS with 0x11 held and 0x22 written during frame 1 → POCI 0x11 then 0x22; RX delivers both words in order.
- Hold `rx_ready_i`=0 across two received words 0x01, 0x02 → `rx_data_o` stays 0x01 and `overrun_o`=1 persists after CS deasserts.
- CS deasserted after 5 bits, then a full 0x5A frame → no valid word for the partial frame; next word is 0x5A.
- `reset_n_i` low mid-frame → all outputs return to reset values on the next edge; a following frame is received correctly.
